rgmii_rx: RTL and testbench
===========================

# rgmii_rx

Receive-side frame engine for the 1000BASE-T RGMII link; the counterpart of the transmit path that drives `txd`/`txctl` from `clk125`. It runs on the PHY-sourced `rxclk` and takes the rising/falling-edge halves produced by the pad DDR input cells. It reassembles GMII bytes, strips preamble/SFD and FCS, and checks the CRC-32. Payload is delivered as a byte stream with end-of-frame and error flags, plus good/bad frame counters for the status logic.

## Interface
- `MIN_LEN`, 64: minimum frame length in bytes, DA through FCS inclusive.
- `MAX_LEN`, 1518: maximum frame length in bytes, DA through FCS inclusive.
- `rxclk` in 1: 125 MHz receive clock. One clock; every register in the block is on its rising edge.
- `rstn` in 1: reset. Asynchronous, active-low.
- `rxd_r` in 4: DDR capture, rising-edge nibble, which is GMII bits [3:0].
- `rxd_f` in 4: DDR capture, falling-edge nibble, which is GMII bits [7:4].
- `rxctl_r` in 1: rising-edge `rxctl`, which is `rx_dv`.
- `rxctl_f` in 1: falling-edge `rxctl`. `rx_er = rxctl_r ^ rxctl_f`.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid this cycle. There is no backpressure.
- `out_last` out 1: qualifies the final payload byte of a frame.
- `out_err` out 1: valid only when `out_last` is high. 1 means the frame is bad.
- `frame_ok` out 16: count of good frames. Wraps.
- `frame_bad` out 16: count of bad or dropped frames. Wraps.

## Operation
- Byte assembly: `byte = {rxd_f, rxd_r}` and `dv = rxctl_r`, both sampled at every edge.
- State IDLE:
  - `dv=0`: stay in IDLE.
  - `dv=1` and byte 0x55: go to PRE.
  - `dv=1` and byte 0xD5: go to DATA.
  - `dv=1` and any other byte: go to DROP and increment `frame_bad`.
- State PRE:
  - 0x55: stay in PRE.
  - 0xD5: go to DATA. Clear the CRC register to 0xFFFFFFFF, clear the length count and clear the error flag.
  - Any other byte: go to DROP and increment `frame_bad`.
  - `dv=0`: go to IDLE. No count.
- State DATA:
  - Each sampled byte updates the CRC: reflected polynomial 0xEDB88320, LSB-first.
  - Each sampled byte shifts into a 5-entry delay line (4 FCS bytes plus 1 pending) and increments an 11-bit length count that saturates at 2047.
  - `rx_er=1` on any DATA byte sets a sticky error flag.
  - Once the line is full, every new byte pushes the oldest entry out as `out_valid=1`, `out_last=0`.
- End of frame, first edge with `dv=0` in DATA:
  - If length ≥ 5, emit the oldest entry with `out_last=1`.
  - `out_err = (crc != 0xDEBB20E3) | err_flag | (len < MIN_LEN)`.
  - Increment `frame_ok` if `out_err=0`, otherwise increment `frame_bad`.
  - If length < 5, nothing is emitted and `frame_bad` is incremented.
  - Return to IDLE.
- Oversize: when the sampled byte makes len = MAX_LEN+1:
  - Emit the oldest entry with `out_last=1`, `out_err=1`.
  - Increment `frame_bad` and go to DROP.
- State DROP: discard everything until `dv=0`, then go to IDLE.
- `rx_er=1` while `dv=0` (carrier extension or false carrier) is ignored in every state.
- Exactly one `out_last` is emitted per frame that produced any `out_valid`. Bytes emitted for one frame never interleave with another.

## Timing
- Reset values: all outputs 0, delay line cleared, state IDLE.
- Latency: a DATA byte sampled at edge n appears on `out_*` in the cycle after edge n+5. This holds for the final payload byte too: it leaves on the `dv`-low edge five edges after it was sampled.
- Outputs are driven directly from registers, with no combinational path from the inputs.
- Counters update on the same edge that asserts `out_last`, or the DROP/runt decision edge.
- Back-to-back frames:
  - The minimum gap is one `dv=0` cycle.
  - The end-of-frame emission and the next frame's IDLE→PRE transition happen on the same edge without loss.
- Reset mid-frame:
  - Outputs drop immediately.
  - After release with `dv` still high, the first non-preamble byte sends the engine to DROP, so the partial frame is never emitted.

## Structure
- Package `eth_pkg` holds:
  - The constants `PREAMBLE=8'h55`, `SFD=8'hD5`, `CRC_POLY=32'hEDB88320`, `CRC_INIT=32'hFFFFFFFF`, `CRC_RESIDUE=32'hDEBB20E3`.
  - The state enum {IDLE, PRE, DATA, DROP}.
- Sub-module `eth_crc32_d8`: combinational function taking a 32-bit current value and an 8-bit byte and returning the next value. The transmit side reuses it for FCS generation.

## Test plan
- Valid frame: 7×0x55, 0xD5, then 60 bytes 0x00..0x3B, then the correct FCS from the bench model.
  - Required: 60 `out_valid` beats with data 0x00..0x3B.
  - `out_last` on 0x3B with `out_err=0`, `frame_ok=1`.
  - First beat appears 5 cycles after its sample edge.
- Same frame with the last FCS byte XOR 0x01: identical data beats, then `out_last` with `out_err=1` and `frame_bad=1`.
- Runt frames:
  - 0xD5 plus 3 bytes, then `dv` low: no `out_valid`, `frame_bad` +1.
  - 40-byte frame with a correct FCS: 36 beats, `out_err=1`.
- `rx_er` pulse (`rxctl_f` inverted) on payload byte 10 of an otherwise good 64-byte frame: all beats are delivered, `out_err=1`.
- Oversize: 1600-byte frame.
  - `out_last` with `out_err=1` on the beat triggered by byte 1519, then no further beats until `dv` low.
  - `frame_bad` +1.
  - A following good frame after a 1-cycle gap gives `frame_ok` +1.
- Mid-frame reset: `rstn` low for 3 cycles at payload byte 20.
  - All outputs are 0 during reset.
  - After release, no beats until the next preamble.
  - The next good frame is received intact.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and the frame-engine state encoding.
package eth_pkg;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
endpackage

// File: rtl/rgmii_rx_if.sv
// RGMII receive pad-side nibbles in, payload stream and frame counters out.
interface rgmii_rx_if;
    logic [3:0]  rxd_r;
    logic [3:0]  rxd_f;
    logic        rxctl_r;
    logic        rxctl_f;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_err;
    logic [15:0] frame_ok;
    logic [15:0] frame_bad;

    modport master (output rxd_r, rxd_f, rxctl_r, rxctl_f,
                    input  out_data, out_valid, out_last, out_err, frame_ok, frame_bad);
    modport slave  (input  rxd_r, rxd_f, rxctl_r, rxctl_f,
                    output out_data, out_valid, out_last, out_err, frame_ok, frame_bad);
endinterface

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, shared with the transmit FCS generator.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    always_comb begin
        o_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            o_crc = (o_crc[0] ^ i_data[i]) ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
        end
    end
endmodule

// File: rtl/rgmii_rx.sv
// RGMII receive frame engine: strips preamble/SFD and FCS, checks CRC-32 and length,
// and delivers payload bytes with end-of-frame status plus good/bad frame counters.
module rgmii_rx
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic       rxclk,
    input  logic       rstn,
    rgmii_rx_if.slave  bus
);
    localparam logic [10:0] LP_MIN = 11'(MIN_LEN);
    localparam logic [10:0] LP_MAX = 11'(MAX_LEN);

    logic [7:0]  w_byte;
    logic        w_dv;
    logic        w_er;
    logic [31:0] w_crc_nxt;
    logic        w_frame_bad;

    state_t          r_state;
    logic [31:0]     r_crc;
    logic [10:0]     r_len;
    logic            r_err;
    logic [4:0][7:0] r_dly;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_last;
    logic            r_oerr;
    logic [15:0]     r_ok;
    logic [15:0]     r_bad;

    assign w_byte = {bus.rxd_f, bus.rxd_r};
    assign w_dv   = bus.rxctl_r;
    assign w_er   = bus.rxctl_r ^ bus.rxctl_f;
    assign w_frame_bad = (r_crc != CRC_RESIDUE) | r_err | (r_len < LP_MIN);

    eth_crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_nxt)
    );

    always_ff @(posedge rxclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_crc   <= CRC_INIT;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_dly   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_oerr  <= 1'b0;
            r_ok    <= '0;
            r_bad   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_oerr  <= 1'b0;
            case (r_state)
                IDLE, PRE: begin
                    if (!w_dv) begin
                        r_state <= IDLE;
                    end else if (w_byte == PREAMBLE) begin
                        r_state <= PRE;
                    end else if (w_byte == SFD) begin
                        r_state <= DATA;
                        r_crc   <= CRC_INIT;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                    end else begin
                        r_state <= DROP;
                        r_bad   <= r_bad + 16'd1;
                    end
                end
                DATA: begin
                    if (w_dv) begin
                        r_crc <= w_crc_nxt;
                        r_dly <= {r_dly[3:0], w_byte};
                        r_len <= (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
                        if (w_er) r_err <= 1'b1;
                        // Four FCS bytes plus one pending must be held before anything leaves.
                        if (r_len >= 11'd5) begin
                            r_valid <= 1'b1;
                            r_data  <= r_dly[4];
                        end
                        if (r_len == LP_MAX) begin
                            r_last  <= 1'b1;
                            r_oerr  <= 1'b1;
                            r_bad   <= r_bad + 16'd1;
                            r_state <= DROP;
                        end
                    end else begin
                        r_state <= IDLE;
                        if (r_len >= 11'd5) begin
                            r_valid <= 1'b1;
                            r_last  <= 1'b1;
                            r_data  <= r_dly[4];
                            r_oerr  <= w_frame_bad;
                            if (w_frame_bad) r_bad <= r_bad + 16'd1;
                            else             r_ok  <= r_ok + 16'd1;
                        end else begin
                            r_bad <= r_bad + 16'd1;
                        end
                    end
                end
                DROP: begin
                    if (!w_dv) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign bus.out_err   = r_oerr;
    assign bus.frame_ok  = r_ok;
    assign bus.frame_bad = r_bad;
endmodule

// File: tb/tb_rgmii_rx.sv
// Randomized bench for rgmii_rx: frames are scored against a frame-level model
// (FCS compare, length rules) and an expected-beat queue.
module tb_rgmii_rx;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    logic rxclk = 1'b0;
    logic rstn  = 1'b0;
    always #4 rxclk = ~rxclk;

    rgmii_rx_if bus();

    rgmii_rx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .rxclk (rxclk),
        .rstn  (rstn),
        .bus   (bus)
    );

    beat_t      exp_q[$];
    logic [7:0] frm[$];
    int         total = 0;
    int         nbad  = 0;
    int         cyc   = 0;
    int         t_first = 0;
    bit         want_lat = 0;
    bit         first = 0;
    logic [15:0] m_ok  = 16'd0;
    logic [15:0] m_bad = 16'd0;
    beat_t      mon_e;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge rxclk) cyc <= cyc + 1;

    // Scoreboard: every beat must match the head of the expected queue.
    always @(negedge rxclk) begin
        if (bus.out_valid === 1'b1) begin
            if (want_lat) begin
                check_val("latency", cyc - t_first, 5);
                want_lat = 0;
            end
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("beat_data", {24'h0, bus.out_data}, {24'h0, mon_e.d});
                check_val("beat_last", {31'h0, bus.out_last}, {31'h0, mon_e.last});
                if (mon_e.last) check_val("beat_err", {31'h0, bus.out_err}, {31'h0, mon_e.err});
            end
        end
    end

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic set_in(input bit dv, input logic [7:0] b, input bit er);
        bus.rxd_r   = b[3:0];
        bus.rxd_f   = b[7:4];
        bus.rxctl_r = dv;
        bus.rxctl_f = dv ^ er;
    endtask

    task automatic step();
        @(negedge rxclk);
        #1;
    endtask

    task automatic drive(input bit dv, input logic [7:0] b, input bit er);
        if (!first) step();
        first = 0;
        set_in(dv, b, er);
    endtask

    task automatic pay_seq(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
    endtask

    task automatic pay_rand(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    endtask

    task automatic add_fcs(input bit corrupt);
        logic [31:0] f;
        f = fcs_of(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
        if (corrupt) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    endtask

    task automatic push_beat(input logic [7:0] d, input bit last, input bit err);
        beat_t b;
        b.d = d; b.last = last; b.err = err;
        exp_q.push_back(b);
    endtask

    // Frame-level expectation from the length, FCS and rx_er rules.
    task automatic model(input int er_idx);
        int L;
        bit crc_ok, e;
        L = frm.size();
        if (L > MAX_LEN) begin
            for (int j = 0; j <= MAX_LEN - 5; j++) push_beat(frm[j], j == MAX_LEN - 5, 1'b1);
            m_bad++;
        end else if (L < 5) begin
            m_bad++;
        end else begin
            crc_ok = (fcs_of(L - 4) == {frm[L-1], frm[L-2], frm[L-3], frm[L-4]});
            e = !crc_ok || (er_idx >= 0) || (L < MIN_LEN);
            for (int j = 0; j <= L - 5; j++) push_beat(frm[j], j == L - 5, e);
            if (e) m_bad++;
            else   m_ok++;
        end
    endtask

    task automatic check_counts();
        check_val("frame_ok", {16'h0, bus.frame_ok}, {16'h0, m_ok});
        check_val("frame_bad", {16'h0, bus.frame_bad}, {16'h0, m_bad});
        check_val("beats_drained", exp_q.size(), 0);
    endtask

    // kind: 0 normal frame, 1 junk start (dropped), 2 preamble abort (no count)
    task automatic send(input int kind, input int npre, input bit sfd, input int er_idx,
                        input int gap, input bit lat);
        step();
        check_counts();
        first = 1;
        if (kind == 0) model(er_idx);
        else if (kind == 1) m_bad++;
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
        if (sfd) drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, frm[i], i == er_idx);
            if (i == 0 && lat) begin
                t_first  = cyc + 1;
                want_lat = 1;
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic reset_frame();
        step();
        check_counts();
        first = 1;
        pay_seq(60);
        add_fcs(1'b0);
        for (int j = 0; j < 15; j++) push_beat(frm[j], 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            step();
            if (i == 20) begin
                check_val("beats_before_reset", exp_q.size(), 0);
                rstn  = 1'b0;
                m_ok  = 16'd0;
                m_bad = 16'd0;
            end
            if (i >= 21 && i <= 23) begin
                check_val("rst_valid", {31'h0, bus.out_valid}, 0);
                check_val("rst_last", {31'h0, bus.out_last}, 0);
                check_val("rst_data", {24'h0, bus.out_data}, 0);
                check_val("rst_ok", {16'h0, bus.frame_ok}, 0);
                check_val("rst_bad", {16'h0, bus.frame_bad}, 0);
            end
            if (i == 23) rstn = 1'b1;
            set_in(1'b1, frm[i], 1'b0);
        end
        m_bad = 16'd1;
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, n, er;
        set_in(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge rxclk);
        check_val("reset_valid", {31'h0, bus.out_valid}, 0);
        check_val("reset_last", {31'h0, bus.out_last}, 0);
        check_val("reset_err", {31'h0, bus.out_err}, 0);
        check_val("reset_data", {24'h0, bus.out_data}, 0);
        check_val("reset_ok", {16'h0, bus.frame_ok}, 0);
        check_val("reset_bad", {16'h0, bus.frame_bad}, 0);
        #1 rstn = 1'b1;
        step();

        pay_seq(60); add_fcs(1'b0); send(0, 7, 1'b1, -1, 2, 1'b1);
        pay_seq(60); add_fcs(1'b1); send(0, 7, 1'b1, -1, 2, 1'b0);
        pay_rand(3);                send(0, 7, 1'b1, -1, 2, 1'b0);
        pay_rand(36); add_fcs(1'b0); send(0, 7, 1'b1, -1, 2, 1'b0);
        pay_rand(60); add_fcs(1'b0); send(0, 7, 1'b1, 10, 1, 1'b0);
        pay_rand(1600);             send(0, 7, 1'b1, -1, 1, 1'b0);
        pay_rand(60); add_fcs(1'b0); send(0, 7, 1'b1, -1, 1, 1'b0);
        reset_frame();
        pay_rand(60); add_fcs(1'b0); send(0, 7, 1'b1, -1, 1, 1'b0);

        for (int f = 0; f < 30; f++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                pay_rand($urandom_range(3, 10));
                frm[0] = 8'h12;
                send(1, 0, 1'b0, -1, $urandom_range(1, 3), 1'b0);
            end else if (r < 16) begin
                frm.delete();
                send(2, $urandom_range(1, 4), 1'b0, -1, $urandom_range(1, 3), 1'b0);
            end else if (r < 26) begin
                pay_rand($urandom_range(0, 4));
                send(0, $urandom_range(0, 7), 1'b1, -1, $urandom_range(1, 3), 1'b0);
            end else begin
                n = $urandom_range(30, 100);
                pay_rand(n);
                add_fcs(r % 4 == 0);
                er = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n + 3) : -1;
                send(0, $urandom_range(0, 7), 1'b1, er, $urandom_range(1, 3), 1'b0);
            end
        end

        step();
        check_counts();
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
